// File: rtl/slc3_control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : slc3_control_seq
//  Description : Moore-style fetch/decode/execute sequencer for the SLC-3
//                datapath. One control word per cycle, decoded from the
//                current state, the opcode and IR[5].
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MEM_WAIT   : cycles a memory strobe is held per access (1..15)
//  Optional feature
//    SLC3_PAUSE_EN : when defined, opcode 1101 enters PAUSE0/PAUSE1 and drives
//                    LD_LED. When undefined, 1101 is treated as illegal,
//                    LD_LED stays 0 and Continue is ignored.
//  Ports
//    Clk, Reset(async, active-low) : clock / reset (reset forces HALTED)
//    Run, Continue                 : start from HALTED / resume from PAUSE
//    Opcode, IR_5, BEN             : instruction fields and branch enable
//    LD_*                          : register load enables
//    Gate*                         : bus drivers (at most one high)
//    PCMUX, ADDR2MUX, ALUK         : 2-bit selects
//    DRMUX, SR1MUX, SR2MUX,
//    ADDR1MUX, MIO_EN              : 1-bit selects
//    Mem_OE, Mem_WE                : active-low memory strobes
// ============================================================================
module slc3_control_seq #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
`ifdef SLC3_PAUSE_EN
    localparam logic [3:0] OP_PSE = 4'b1101;
`endif

    // Last count value of a memory access; the strobe is held MEM_WAIT cycles.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        S_HALTED = 5'd0,
        S_FETCH1 = 5'd1,
        S_FETCH2 = 5'd2,
        S_FETCH3 = 5'd3,
        S_DECODE = 5'd4,
        S_ALU    = 5'd5,
        S_BR0    = 5'd6,
        S_BR1    = 5'd7,
        S_JMP    = 5'd8,
        S_JSR0   = 5'd9,
        S_JSR1   = 5'd10,
        S_LDR0   = 5'd11,
        S_LDR1   = 5'd12,
        S_LDR2   = 5'd13,
        S_STR0   = 5'd14,
        S_STR1   = 5'd15,
        S_STR2   = 5'd16
`ifdef SLC3_PAUSE_EN
        ,
        S_PAUSE0 = 5'd17,
        S_PAUSE1 = 5'd18
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       w_wait_last;

`ifndef SLC3_PAUSE_EN
    // Continue has no consumer without the pause feature.
    logic w_unused_continue;
    assign w_unused_continue = Continue;
`endif

    assign w_wait_last = (wait_q == WAIT_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_HALTED;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        // Idle control word; every state overrides only what it needs.
        state_d    = state_q;
        wait_d     = 4'd0;   // non-memory states keep the counter cleared
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'd0;
        ADDR2MUX   = 2'd0;
        ALUK       = 2'd0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        case (state_q)
            S_HALTED: begin
                if (Run) begin
                    state_d = S_FETCH1;
                end
            end

            S_FETCH1: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                state_d = S_FETCH2;
            end

            // Instruction fetch and LDR data read share one read protocol:
            // hold OE for MEM_WAIT cycles, capture MDR on the final one.
            S_FETCH2, S_LDR1: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = w_wait_last;
                if (w_wait_last) begin
                    state_d = (state_q == S_FETCH2) ? S_FETCH3 : S_LDR2;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD, OP_AND, OP_NOT: state_d = S_ALU;
                    OP_BR:                  state_d = S_BR0;
                    OP_JMP:                 state_d = S_JMP;
                    OP_JSR:                 state_d = S_JSR0;
                    OP_LDR:                 state_d = S_LDR0;
                    OP_STR:                 state_d = S_STR0;
`ifdef SLC3_PAUSE_EN
                    OP_PSE:                 state_d = S_PAUSE0;
`endif
                    default:                state_d = S_FETCH1;
                endcase
            end

            S_ALU: begin
                SR1MUX  = 1'b1;
                // NOT has no second operand, so the immediate select is forced off.
                SR2MUX  = (Opcode == OP_NOT) ? 1'b0 : IR_5;
                case (Opcode)
                    OP_AND:  ALUK = 2'd1;
                    OP_NOT:  ALUK = 2'd2;
                    default: ALUK = 2'd0;
                endcase
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S_FETCH1;
            end

            S_BR0: begin
                state_d = BEN ? S_BR1 : S_FETCH1;
            end

            S_BR1: begin
                ADDR2MUX = 2'd1;
                PCMUX    = 2'd2;
                LD_PC    = 1'b1;
                state_d  = S_FETCH1;
            end

            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'd3;
                PCMUX    = 2'd2;
                LD_PC    = 1'b1;
                state_d  = S_FETCH1;
            end

            // R7 <- PC first, then PC <- PC + SEXT(IR[10:0]).
            S_JSR0: begin
                GatePC  = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                state_d = S_JSR1;
            end

            S_JSR1: begin
                ADDR2MUX = 2'd2;
                PCMUX    = 2'd2;
                LD_PC    = 1'b1;
                state_d  = S_FETCH1;
            end

            // MAR <- SR1 + SEXT(IR[5:0]) for both loads and stores.
            S_LDR0, S_STR0: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == S_LDR0) ? S_LDR1 : S_STR1;
            end

            S_LDR2: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S_FETCH1;
            end

            // Store data comes from IR[11:9] passed straight through the ALU.
            S_STR1: begin
                ALUK    = 2'd3;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = S_STR2;
            end

            S_STR2: begin
                Mem_WE = 1'b0;
                if (w_wait_last) begin
                    state_d = S_FETCH1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

`ifdef SLC3_PAUSE_EN
            // Two-phase handshake: Continue must rise and then fall, so a
            // Continue held high cannot carry through into a later pause.
            S_PAUSE0: begin
                LD_LED = 1'b1;
                if (Continue) begin
                    state_d = S_PAUSE1;
                end
            end

            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (!Continue) begin
                    state_d = S_FETCH1;
                end
            end
`endif

            default: begin
                state_d = S_HALTED;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_slc3_control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slc3_control_seq
//  Description : Self-checking bench for slc3_control_seq: opcode table,
//                randomized instruction stream against a per-instruction
//                control-word model, async reset mid-fetch, pause handshake.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_slc3_control_seq;

    localparam int W = 3;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

    always #5 Clk = ~Clk;

    slc3_control_seq #(.MEM_WAIT(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
        .ALUK(ALUK), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    // Control word bit positions (bench-local packing).
    localparam logic [24:0] K_LD_MAR  = 25'b1 << 0;
    localparam logic [24:0] K_LD_MDR  = 25'b1 << 1;
    localparam logic [24:0] K_LD_IR   = 25'b1 << 2;
    localparam logic [24:0] K_LD_BEN  = 25'b1 << 3;
    localparam logic [24:0] K_LD_CC   = 25'b1 << 4;
    localparam logic [24:0] K_LD_REG  = 25'b1 << 5;
    localparam logic [24:0] K_LD_PC   = 25'b1 << 6;
    localparam logic [24:0] K_LD_LED  = 25'b1 << 7;
    localparam logic [24:0] K_GPC     = 25'b1 << 8;
    localparam logic [24:0] K_GMDR    = 25'b1 << 9;
    localparam logic [24:0] K_GALU    = 25'b1 << 10;
    localparam logic [24:0] K_GMAR    = 25'b1 << 11;
    localparam logic [24:0] K_PC_ADD  = 25'd2 << 12;
    localparam logic [24:0] K_A2_9    = 25'd1 << 14;
    localparam logic [24:0] K_A2_11   = 25'd2 << 14;
    localparam logic [24:0] K_A2_ZERO = 25'd3 << 14;
    localparam logic [24:0] K_ALUK_AND  = 25'd1 << 16;
    localparam logic [24:0] K_ALUK_NOT  = 25'd2 << 16;
    localparam logic [24:0] K_ALUK_PASS = 25'd3 << 16;
    localparam logic [24:0] K_DRMUX   = 25'b1 << 18;
    localparam logic [24:0] K_SR1     = 25'b1 << 19;
    localparam logic [24:0] K_SR2     = 25'b1 << 20;
    localparam logic [24:0] K_ADDR1   = 25'b1 << 21;
    localparam logic [24:0] K_MIO     = 25'b1 << 22;
    localparam logic [24:0] K_OE      = 25'b1 << 23;
    localparam logic [24:0] K_WE      = 25'b1 << 24;

    localparam logic [24:0] K_IDLE  = K_OE | K_WE;
    localparam logic [24:0] K_F1    = K_IDLE | K_GPC | K_LD_MAR | K_LD_PC;
    localparam logic [24:0] K_RD    = K_WE | K_MIO;
    localparam logic [24:0] K_F3    = K_IDLE | K_GMDR | K_LD_IR;
    localparam logic [24:0] K_DEC   = K_IDLE | K_LD_BEN;
    localparam logic [24:0] K_ALU   = K_IDLE | K_SR1 | K_GALU | K_LD_REG | K_LD_CC;
    localparam logic [24:0] K_BR1   = K_IDLE | K_A2_9 | K_PC_ADD | K_LD_PC;
    localparam logic [24:0] K_JMP   = K_IDLE | K_SR1 | K_ADDR1 | K_A2_ZERO | K_PC_ADD | K_LD_PC;
    localparam logic [24:0] K_JSR0  = K_IDLE | K_GPC | K_DRMUX | K_LD_REG;
    localparam logic [24:0] K_JSR1  = K_IDLE | K_A2_11 | K_PC_ADD | K_LD_PC;
    localparam logic [24:0] K_LDR0  = K_IDLE | K_SR1 | K_ADDR1 | K_GMAR | K_LD_MAR;
    localparam logic [24:0] K_LDR2  = K_IDLE | K_GMDR | K_LD_REG | K_LD_CC;
    localparam logic [24:0] K_STR1  = K_IDLE | K_ALUK_PASS | K_GALU | K_LD_MDR;
    localparam logic [24:0] K_STR2  = K_OE;
    localparam logic [24:0] K_PAUSE = K_IDLE | K_LD_LED;

    int checks   = 0;
    int failures = 0;
    logic [24:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic        ir5;
        logic        ben;
        int          cycles;   // FETCH1 to next FETCH1
        logic [24:0] exec;     // word in the cycle after DECODE
    } vec_t;

    vec_t tbl[12];

    function automatic logic [24:0] cw();
        return {Mem_WE, Mem_OE, MIO_EN, ADDR1MUX, SR2MUX, SR1MUX, DRMUX, ALUK,
                ADDR2MUX, PCMUX, GateMARMUX, GateALU, GateMDR, GatePC, LD_LED,
                LD_PC, LD_REG, LD_CC, LD_BEN, LD_IR, LD_MDR, LD_MAR};
    endfunction

    task automatic check_inv(input string name);
        checks++;
        if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1 ||
            (Mem_OE === 1'b0 && Mem_WE === 1'b0)) begin
            failures++;
            $display("FAIL %s_invariant gates=%b oe=%b we=%b (required <=1 gate, strobes not both low) t=%0t",
                     name, {GatePC, GateMDR, GateALU, GateMARMUX}, Mem_OE, Mem_WE, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [24:0] exp);
        logic [24:0] act;
        act = cw();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
        check_inv(name);
    endtask

    // Advance one cycle; returns just after the falling edge (sample point).
    task automatic step();
        @(posedge Clk);
        #1;
        @(negedge Clk);
    endtask

    // Reference model: the control words an instruction produces after its
    // FETCH1 cycle, derived from the instruction semantics.
    task automatic model_instr(input logic [3:0] op, input logic ir5, input logic ben);
        logic [24:0] a;
        for (int i = 0; i < W; i++) exp_q.push_back((i == W - 1) ? (K_RD | K_LD_MDR) : K_RD);
        exp_q.push_back(K_F3);
        exp_q.push_back(K_DEC);
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                a = K_ALU;
                if (op == 4'b0101) a = a | K_ALUK_AND;
                if (op == 4'b1001) a = a | K_ALUK_NOT;
                if (op != 4'b1001 && ir5) a = a | K_SR2;
                exp_q.push_back(a);
            end
            4'b0000: begin
                exp_q.push_back(K_IDLE);
                if (ben) exp_q.push_back(K_BR1);
            end
            4'b1100: exp_q.push_back(K_JMP);
            4'b0100: begin
                exp_q.push_back(K_JSR0);
                exp_q.push_back(K_JSR1);
            end
            4'b0110: begin
                exp_q.push_back(K_LDR0);
                for (int i = 0; i < W; i++) exp_q.push_back((i == W - 1) ? (K_RD | K_LD_MDR) : K_RD);
                exp_q.push_back(K_LDR2);
            end
            4'b0111: begin
                exp_q.push_back(K_LDR0);
                exp_q.push_back(K_STR1);
                for (int i = 0; i < W; i++) exp_q.push_back(K_STR2);
            end
            default: ;
        endcase
    endtask

    // Run the modelled words for one instruction, then expect FETCH1 again.
    task automatic run_model(input string name, input bit rand_ctl);
        while (exp_q.size() > 0) begin
            @(posedge Clk);
            #1;
            if (rand_ctl) begin
                Run      = 1'($urandom);
                Continue = 1'($urandom);
            end
            @(negedge Clk);
            check_word(name, exp_q.pop_front());
        end
        step();
        check_word({name, "_next_fetch1"}, K_F1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        tbl[0]  = '{4'b0001, 1'b1, 1'b0, 4 + W,     K_ALU | K_SR2};
        tbl[1]  = '{4'b0001, 1'b0, 1'b1, 4 + W,     K_ALU};
        tbl[2]  = '{4'b0101, 1'b1, 1'b0, 4 + W,     K_ALU | K_SR2 | K_ALUK_AND};
        tbl[3]  = '{4'b1001, 1'b1, 1'b0, 4 + W,     K_ALU | K_ALUK_NOT};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4 + W,     K_IDLE};
        tbl[5]  = '{4'b0000, 1'b0, 1'b1, 5 + W,     K_IDLE};
        tbl[6]  = '{4'b1100, 1'b0, 1'b0, 4 + W,     K_JMP};
        tbl[7]  = '{4'b0100, 1'b0, 1'b0, 5 + W,     K_JSR0};
        tbl[8]  = '{4'b0110, 1'b0, 1'b0, 5 + 2 * W, K_LDR0};
        tbl[9]  = '{4'b0111, 1'b0, 1'b0, 5 + 2 * W, K_LDR0};
        tbl[10] = '{4'b0011, 1'b0, 1'b0, 3 + W,     K_F1};
`ifdef SLC3_PAUSE_EN
        tbl[11] = '{4'b1111, 1'b0, 1'b0, 3 + W,     K_F1};
`else
        tbl[11] = '{4'b1101, 1'b0, 1'b0, 3 + W,     K_F1};
`endif

        Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'd0; IR_5 = 1'b0; BEN = 1'b0;

        @(negedge Clk);
        check_word("reset_idle", K_IDLE);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        check_word("halted_hold", K_IDLE);
        Run = 1'b1;
        step();
        Run = 1'b0;

        // Opcode table: exec-cycle control word and FETCH1-to-FETCH1 length.
        for (int i = 0; i < 12; i++) begin
            check_word($sformatf("tbl%0d_fetch1", i), K_F1);
            Opcode = tbl[i].op;
            IR_5   = tbl[i].ir5;
            BEN    = tbl[i].ben;
            cyc    = 0;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (c == W + 3) check_word($sformatf("tbl%0d_exec", i), tbl[i].exec);
                else            check_inv($sformatf("tbl%0d_cyc%0d", i, c));
                if (cw() == K_F1) begin
                    cyc = c;
                    break;
                end
            end
            checks++;
            if (cyc != tbl[i].cycles) begin
                failures++;
                $display("FAIL tbl%0d_cycles actual=%0d required=%0d", i, cyc, tbl[i].cycles);
            end
        end

        // Randomized instruction stream; Run/Continue toggled randomly.
        for (int n = 0; n < 60; n++) begin
            Opcode = 4'($urandom_range(0, 15));
`ifdef SLC3_PAUSE_EN
            if (Opcode == 4'b1101) Opcode = 4'b0001;
`endif
            IR_5 = 1'($urandom);
            BEN  = 1'($urandom);
            model_instr(Opcode, IR_5, BEN);
            run_model($sformatf("rand%0d_op%b", n, Opcode), 1'b1);
        end
        Run = 1'b0;
        Continue = 1'b0;

`ifdef SLC3_PAUSE_EN
        // Pause with Continue already high: 10 LED cycles, one return.
        Opcode = 4'b1101;
        Continue = 1'b1;
        model_instr(4'b1111, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            step();
            check_word("pause_fetch", exp_q.pop_front());
        end
        for (int i = 0; i < 10; i++) begin
            step();
            check_word($sformatf("pause_led%0d", i), K_PAUSE);
        end
        Continue = 1'b0;
        step();
        check_word("pause_return", K_F1);
        Opcode = 4'b0001;
        IR_5 = 1'b0;
        Continue = 1'b1;
        model_instr(4'b0001, 1'b0, 1'b0);
        run_model("after_pause", 1'b0);
        Continue = 1'b0;
`endif

        // Async reset in the middle of FETCH2 with the counter non-zero.
        Opcode = 4'b0001;
        IR_5 = 1'b1;
        step();
        check_word("f2_first", K_RD);
        step();
        check_word("f2_second", K_RD);
        #2 Reset = 1'b0;
        #1 check_word("reset_async", K_IDLE);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        check_word("halted_after_reset", K_IDLE);
        step();
        check_word("halted_no_run", K_IDLE);
        Run = 1'b1;
        step();
        Run = 1'b0;
        check_word("run_fetch1", K_F1);
        model_instr(4'b0001, 1'b1, 1'b0);
        run_model("post_reset_add", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
